wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port (WE3/A3/WD3) between the in-order

---
 rtl/wb_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order writeback has priority, MUL/DIV
// results queue in a small compacting FIFO and drain into idle slots. A wait
// counter forces the FIFO head through by stalling writeback for one cycle.
module wb_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteW,
    input  logic [4:0]            RdW,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic                  MValid,
    input  logic [4:0]            MRd,
    input  logic [DATA_WIDTH-1:0] MResult,
    output logic                  MReady,
    output logic                  WE3,
    output logic [4:0]            A3,
    output logic [DATA_WIDTH-1:0] WD3,
    output logic                  StallW,
    output logic [31:0]           PendingMask
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        G_NONE,
        G_FORCE,
        G_PIPE,
        G_DRAIN,
        G_BYPASS
    } grant_t;

    // FIFO is kept compacted: valid entries always occupy slots 0..count-1,
    // slot 0 is the head. Killed entries vanish during compaction, so a pop
    // never spends a write slot on a dead entry.
    logic [DEPTH-1:0]      ent_valid;
    logic [4:0]            ent_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [CW-1:0]         count;
    logic [WW-1:0]         wait_cnt;

    logic [DEPTH-1:0]      nxt_valid;
    logic [4:0]            nxt_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] nxt_data [DEPTH];
    logic [CW-1:0]         nxt_count;
    logic [WW-1:0]         nxt_wait;

    grant_t                grant;
    logic                  pw;
    logic                  nonempty;
    logic                  accept;
    logic                  acc_wr;
    logic                  push;
    logic [DEPTH-1:0]      keep;

    // Request decode and write-port grant, priority ordered
    always_comb begin
        pw       = RegWriteW && (RdW != 5'd0);
        nonempty = (count != '0);
        MReady   = (count < CW'(DEPTH)) && !rst;
        accept   = MValid && MReady;
        acc_wr   = accept && (MRd != 5'd0);
        if (rst)
            grant = G_NONE;
        else if (nonempty && pw && (wait_cnt == WW'(MAX_WAIT)))
            grant = G_FORCE;
        else if (pw)
            grant = G_PIPE;
        else if (nonempty)
            grant = G_DRAIN;
        else if (acc_wr)
            grant = G_BYPASS;
        else
            grant = G_NONE;
    end

    // Write-port outputs driven from the grant
    always_comb begin
        WE3    = 1'b0;
        A3     = '0;
        WD3    = '0;
        StallW = 1'b0;
        case (grant)
            G_FORCE: begin
                WE3    = 1'b1;
                A3     = ent_rd[0];
                WD3    = ent_data[0];
                StallW = 1'b1;
            end
            G_PIPE: begin
                WE3 = 1'b1;
                A3  = RdW;
                WD3 = ResultW;
            end
            G_DRAIN: begin
                WE3 = 1'b1;
                A3  = ent_rd[0];
                WD3 = ent_data[0];
            end
            G_BYPASS: begin
                WE3 = 1'b1;
                A3  = MRd;
                WD3 = MResult;
            end
            default: ;
        endcase
    end

    // Pending-destination mask from registered FIFO contents
    always_comb begin
        PendingMask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && !rst)
                PendingMask[ent_rd[i]] = 1'b1;
        end
    end

    // Next FIFO contents: kill/pop, compact survivors, append accepted result
    always_comb begin
        int unsigned n;
        nxt_valid = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            nxt_rd[j]   = '0;
            nxt_data[j] = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            keep[i] = ent_valid[i];
            if (grant == G_PIPE && ent_rd[i] == RdW)
                keep[i] = 1'b0;
        end
        if (grant == G_FORCE || grant == G_DRAIN)
            keep[0] = 1'b0;

        n = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (keep[i]) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (j == n) begin
                        nxt_valid[j] = 1'b1;
                        nxt_rd[j]    = ent_rd[i];
                        nxt_data[j]  = ent_data[i];
                    end
                end
                n = n + 1;
            end
        end

        // The pipeline write to the same register in this cycle is newer
        push = acc_wr && (grant != G_BYPASS) &&
               !(grant == G_PIPE && MRd == RdW);
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (push && j == n) begin
                nxt_valid[j] = 1'b1;
                nxt_rd[j]    = MRd;
                nxt_data[j]  = MResult;
            end
        end
        nxt_count = CW'(n + (push ? 1 : 0));

        nxt_wait = '0;
        if (grant == G_PIPE && n != 0)
            nxt_wait = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            count     <= '0;
            wait_cnt  <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                ent_rd[j]   <= '0;
                ent_data[j] <= '0;
            end
        end else begin
            ent_valid <= nxt_valid;
            ent_rd    <= nxt_rd;
            ent_data  <= nxt_data;
            count     <= nxt_count;
            wait_cnt  <= nxt_wait;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (DATA_WIDTH=32, DEPTH=2, MAX_WAIT=4).
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        MValid;
    logic [4:0]  MRd;
    logic [31:0] MResult;
    logic        MReady;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        StallW;
    logic [31:0] PendingMask;

    int checks;
    int failures;

    wb_port_arbiter #(
        .DATA_WIDTH(32),
        .DEPTH(2),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .RegWriteW(RegWriteW),
        .RdW(RdW),
        .ResultW(ResultW),
        .MValid(MValid),
        .MRd(MRd),
        .MResult(MResult),
        .MReady(MReady),
        .WE3(WE3),
        .A3(A3),
        .WD3(WD3),
        .StallW(StallW),
        .PendingMask(PendingMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        MValid = 1'b0; MRd = '0; MResult = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h1111;
        MValid = 1'b1; MRd = 5'd5; MResult = 32'h2222;
        cyc();
        #2;
        checks++;
        if (WE3 !== 1'b0 || MReady !== 1'b0 || StallW !== 1'b0 ||
            A3 !== 5'd0 || WD3 !== 32'd0 || PendingMask !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: WE3=%b MReady=%b StallW=%b A3=%0d WD3=%h PM=%h, required all zero",
                     WE3, MReady, StallW, A3, WD3, PendingMask);
        end
        cyc();
        rst = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if (MReady !== 1'b1 || PendingMask !== 32'd0 || WE3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: MReady=%b PM=%h WE3=%b, required 1/0/0", MReady, PendingMask, WE3);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        MValid = 1'b1; MRd = 5'd5; MResult = 32'h1234;
        #2;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h1234 || MReady !== 1'b1 || StallW !== 1'b0) begin
            failures++;
            $display("FAIL bypass: WE3=%b A3=%0d WD3=%h MReady=%b StallW=%b, required 1/5/1234/1/0",
                     WE3, A3, WD3, MReady, StallW);
        end
        cyc();
        MValid = 1'b0;
        #2;
        checks++;
        if (PendingMask !== 32'd0 || WE3 !== 1'b0) begin
            failures++;
            $display("FAIL bypass_not_queued: PM=%h WE3=%b, required 0/0", PendingMask, WE3);
        end
    endtask

    task automatic test_force();
        do_reset();
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hAAAA;
        MValid = 1'b1; MRd = 5'd7; MResult = 32'h7777;
        #2;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'hAAAA || StallW !== 1'b0) begin
            failures++;
            $display("FAIL force_accept_cycle: WE3=%b A3=%0d WD3=%h StallW=%b, required 1/3/aaaa/0",
                     WE3, A3, WD3, StallW);
        end
        cyc();
        MValid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #2;
            checks++;
            if (A3 !== 5'd3 || StallW !== 1'b0 || PendingMask !== 32'h80) begin
                failures++;
                $display("FAIL force_wait%0d: A3=%0d StallW=%b PM=%h, required 3/0/00000080",
                         k, A3, StallW, PendingMask);
            end
            cyc();
        end
        #2;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h7777 || StallW !== 1'b1) begin
            failures++;
            $display("FAIL force_slot: WE3=%b A3=%0d WD3=%h StallW=%b, required 1/7/7777/1",
                     WE3, A3, WD3, StallW);
        end
        cyc();
        #2;
        checks++;
        if (A3 !== 5'd3 || WD3 !== 32'hAAAA || StallW !== 1'b0 || PendingMask !== 32'd0) begin
            failures++;
            $display("FAIL force_after: A3=%0d WD3=%h StallW=%b PM=%h, required 3/aaaa/0/0",
                     A3, WD3, StallW, PendingMask);
        end
    endtask

    task automatic test_full();
        do_reset();
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h11;
        MValid = 1'b1; MRd = 5'd8; MResult = 32'h88;
        #2;
        checks++;
        if (MReady !== 1'b1) begin
            failures++;
            $display("FAIL full_accept0: MReady=%b, required 1", MReady);
        end
        cyc();
        MRd = 5'd9; MResult = 32'h99;
        #2;
        checks++;
        if (MReady !== 1'b1 || A3 !== 5'd1) begin
            failures++;
            $display("FAIL full_accept1: MReady=%b A3=%0d, required 1/1", MReady, A3);
        end
        cyc();
        MRd = 5'd11; MResult = 32'hBB;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++;
            if (MReady !== 1'b0 || PendingMask !== 32'h300 || A3 !== 5'd1 || StallW !== 1'b0) begin
                failures++;
                $display("FAIL full_hold%0d: MReady=%b PM=%h A3=%0d StallW=%b, required 0/00000300/1/0",
                         k, MReady, PendingMask, A3, StallW);
            end
            cyc();
        end
        #2;
        checks++;
        if (StallW !== 1'b1 || A3 !== 5'd8 || WD3 !== 32'h88 || MReady !== 1'b0) begin
            failures++;
            $display("FAIL full_force: StallW=%b A3=%0d WD3=%h MReady=%b, required 1/8/88/0",
                     StallW, A3, WD3, MReady);
        end
        cyc();
        #2;
        checks++;
        if (MReady !== 1'b1 || A3 !== 5'd1 || StallW !== 1'b0 || PendingMask !== 32'h200) begin
            failures++;
            $display("FAIL full_slot_freed: MReady=%b A3=%0d StallW=%b PM=%h, required 1/1/0/00000200",
                     MReady, A3, StallW, PendingMask);
        end
        cyc();
        idle_inputs();
        #2;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'h99 || PendingMask !== 32'hA00) begin
            failures++;
            $display("FAIL drain_first: WE3=%b A3=%0d WD3=%h PM=%h, required 1/9/99/00000a00",
                     WE3, A3, WD3, PendingMask);
        end
        cyc();
        #2;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd11 || WD3 !== 32'hBB || PendingMask !== 32'h800) begin
            failures++;
            $display("FAIL drain_second: WE3=%b A3=%0d WD3=%h PM=%h, required 1/11/bb/00000800",
                     WE3, A3, WD3, PendingMask);
        end
        cyc();
        #2;
        checks++;
        if (WE3 !== 1'b0 || PendingMask !== 32'd0) begin
            failures++;
            $display("FAIL drain_empty: WE3=%b PM=%h, required 0/0", WE3, PendingMask);
        end
    endtask

    task automatic test_waw_kill();
        do_reset();
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h1;
        MValid = 1'b1; MRd = 5'd10; MResult = 32'hDEAD;
        cyc();
        MValid = 1'b0;
        RdW = 5'd10; ResultW = 32'h1010;
        #2;
        checks++;
        if (PendingMask !== 32'h400 || A3 !== 5'd10 || WD3 !== 32'h1010 || StallW !== 1'b0) begin
            failures++;
            $display("FAIL kill_cycle: PM=%h A3=%0d WD3=%h StallW=%b, required 00000400/10/1010/0",
                     PendingMask, A3, WD3, StallW);
        end
        cyc();
        RegWriteW = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #2;
            checks++;
            if (PendingMask !== 32'd0 || WE3 !== 1'b0) begin
                failures++;
                $display("FAIL kill_after%0d: PM=%h WE3=%b A3=%0d, required 0/0", k, PendingMask, WE3, A3);
            end
            cyc();
        end
        RegWriteW = 1'b1; RdW = 5'd12; ResultW = 32'hC;
        MValid = 1'b1; MRd = 5'd12; MResult = 32'hBAD;
        #2;
        checks++;
        if (MReady !== 1'b1 || A3 !== 5'd12 || WD3 !== 32'hC) begin
            failures++;
            $display("FAIL kill_incoming: MReady=%b A3=%0d WD3=%h, required 1/12/c", MReady, A3, WD3);
        end
        cyc();
        idle_inputs();
        #2;
        checks++;
        if (PendingMask !== 32'd0 || WE3 !== 1'b0) begin
            failures++;
            $display("FAIL kill_incoming_after: PM=%h WE3=%b, required 0/0", PendingMask, WE3);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        MValid = 1'b1; MRd = 5'd0; MResult = 32'hFFFF_FFFF;
        #2;
        checks++;
        if (MReady !== 1'b1 || WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0) begin
            failures++;
            $display("FAIL rd0_cycle: MReady=%b WE3=%b A3=%0d WD3=%h, required 1/0/0/0", MReady, WE3, A3, WD3);
        end
        cyc();
        MValid = 1'b0;
        #2;
        checks++;
        if (MReady !== 1'b1 || WE3 !== 1'b0 || PendingMask !== 32'd0) begin
            failures++;
            $display("FAIL rd0_after: MReady=%b WE3=%b PM=%h, required 1/0/0", MReady, WE3, PendingMask);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_bypass();
        test_force();
        test_full();
        test_waw_kill();
        test_rd_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
